uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_cnt.sv | 30 +++
 rtl/uart_rx_cfg.sv | 132 +++++++++++++
 tb/tb_uart_rx_cfg.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud interval counter: free-runs from a clear, strobing at mid-bit and at bit end.
module uart_baud_cnt #(
    parameter int unsigned BIT_CNT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic half_c,
    output logic full_c
);
    localparam int unsigned HALF = BIT_CNT / 2;
    localparam int unsigned CW   = $clog2(BIT_CNT + 1);

    logic [CW-1:0] cnt;

    assign half_c = (cnt == CW'(HALF - 1));
    assign full_c = (cnt == CW'(BIT_CNT - 1));

    // Wraps to zero on the full strobe so it never runs past BIT_CNT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || full_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Parameterised UART receiver with parity/stop checking and a one-word valid/ready output buffer.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       ready,
    output logic       valid,
    output logic [7:0] data,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);
    localparam int unsigned BIT_CNT = CLK_FREQ / BAUD;
    localparam int unsigned IW      = 3;

    rx_state_e     state;
    logic [1:0]    sync;
    logic          din_s;
    logic [IW-1:0] bit_idx;
    logic [7:0]    shreg;
    logic          par_bad;
    logic          stop_bad;
    logic          half_c;
    logic          full_c;
    logic          clr_c;

    assign din_s = sync[1];
    assign clr_c = (state == ST_IDLE) || ((state == ST_START) && half_c);

    uart_baud_cnt #(
        .BIT_CNT(BIT_CNT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_c),
        .half_c (half_c),
        .full_c (full_c)
    );

    // Two-flop synchroniser, reset to the idle line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], din};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            stop_bad   <= 1'b0;
            valid      <= 1'b0;
            data       <= 8'h00;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (valid && ready) begin
                valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (!din_s) begin
                        state    <= ST_START;
                        bit_idx  <= '0;
                        shreg    <= '0;
                        par_bad  <= 1'b0;
                        stop_bad <= 1'b0;
                    end
                end
                ST_START: begin
                    if (half_c) begin
                        state <= din_s ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (full_c) begin
                        shreg[bit_idx] <= din_s;
                        if (bit_idx == IW'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    // Upper shreg bits are zero, so the reduction covers only data bits.
                    if (full_c) begin
                        par_bad <= ((^shreg) ^ din_s) != (PARITY == PARITY_ODD);
                        state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (full_c) begin
                        if (bit_idx == IW'(STOP_BITS - 1)) begin
                            state   <= ST_IDLE;
                            bit_idx <= '0;
                            // A held word that is being accepted this cycle may be replaced.
                            if (!valid || ready) begin
                                valid      <= 1'b1;
                                data       <= shreg;
                                frame_err  <= stop_bad | ~din_s;
                                parity_err <= par_bad;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            stop_bad <= stop_bad | ~din_s;
                            bit_idx  <= bit_idx + IW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Randomised and directed bench for uart_rx_cfg across four framing configurations.
module tb_uart_rx_cfg;

    localparam int BC   = 16;
    localparam int HALF = 8;
    localparam int DB [4] = '{8, 7, 8, 6};
    localparam int PAR[4] = '{0, 2, 0, 1};
    localparam int SB [4] = '{1, 1, 2, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] din;
    logic [3:0] ready;
    logic [3:0] valid;
    logic [3:0] fe;
    logic [3:0] pe;
    logic [3:0] ov;
    logic [7:0] data [4];

    int n_cmp = 0;
    int n_bad = 0;
    int ov_cnt [4] = '{0, 0, 0, 0};
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .din(din[0]), .ready(ready[0]), .valid(valid[0]),
        .data(data[0]), .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ov[0]));
    uart_rx_cfg #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .din(din[1]), .ready(ready[1]), .valid(valid[1]),
        .data(data[1]), .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ov[1]));
    uart_rx_cfg #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .din(din[2]), .ready(ready[2]), .valid(valid[2]),
        .data(data[2]), .frame_err(fe[2]), .parity_err(pe[2]), .overrun(ov[2]));
    uart_rx_cfg #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(6), .PARITY(1), .STOP_BITS(1)) u3 (
        .clk(clk), .rst(rst), .din(din[3]), .ready(ready[3]), .valid(valid[3]),
        .data(data[3]), .frame_err(fe[3]), .parity_err(pe[3]), .overrun(ov[3]));

    function automatic logic [31:0] pack(input int i, input logic [7:0] d, input logic f, input logic p);
        return {20'd0, 2'(i), d, f, p};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Accepted words and overrun pulses, observed on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (valid[i] && ready[i]) got_q.push_back(pack(i, data[i], fe[i], pe[i]));
                if (ov[i]) ov_cnt[i]++;
            end
        end
    end

    task automatic send_frame(input int i, input logic [7:0] d, input bit bad_par,
                              input bit [1:0] bad_stop, input bit expect_it);
        logic [7:0] m;
        int         ones;
        logic       pbit;
        logic       f;
        m    = 8'((1 << DB[i]) - 1);
        ones = 0;
        din[i] = 1'b0;
        cyc(BC);
        for (int b = 0; b < DB[i]; b++) begin
            din[i] = d[b];
            ones += int'(d[b]);
            cyc(BC);
        end
        if (PAR[i] != 0) begin
            pbit = (PAR[i] == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
            din[i] = pbit ^ bad_par;
            cyc(BC);
        end
        f = 1'b0;
        for (int s = 0; s < SB[i]; s++) begin
            if (bad_stop[s]) begin
                f = 1'b1;
                din[i] = 1'b0;
                cyc(HALF + 2);
                din[i] = 1'b1;
                cyc(BC - HALF - 2);
            end else begin
                din[i] = 1'b1;
                cyc(BC);
            end
        end
        din[i] = 1'b1;
        if (expect_it) exp_q.push_back(pack(i, d & m, f, bad_par && (PAR[i] != 0)));
    endtask

    task automatic flush_compare(input string tag);
        int n;
        cyc(2 * BC);
        check_eq({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) check_eq({tag, "_word"}, got_q[k], exp_q[k]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int         i;
        logic [7:0] d;
        bit         bp;
        bit   [1:0] bs;

        din   = '1;
        ready = '1;
        cyc(3);
        for (int k = 0; k < 4; k++) begin
            check_eq("rst_valid", 32'(valid[k]), 0);
            check_eq("rst_data", 32'(data[k]), 0);
            check_eq("rst_ferr", 32'(fe[k]), 0);
            check_eq("rst_perr", 32'(pe[k]), 0);
            check_eq("rst_ovr", 32'(ov[k]), 0);
        end
        rst = 1'b0;
        cyc(4);

        send_frame(0, 8'hA5, 0, 2'b00, 1);
        flush_compare("8n1_a5");

        send_frame(1, 8'h41, 0, 2'b00, 1);
        send_frame(1, 8'h41, 1, 2'b00, 1);
        flush_compare("7e1_41");

        send_frame(2, 8'h3C, 0, 2'b10, 1);
        flush_compare("8n2_stop2");

        send_frame(3, 8'h2B, 0, 2'b00, 1);
        send_frame(3, 8'h2B, 1, 2'b00, 1);
        flush_compare("6o1_2b");

        // Short low glitch must be rejected, then a real frame still lands.
        din[0] = 1'b0;
        cyc(HALF - 2);
        din[0] = 1'b1;
        cyc(3 * BC);
        check_eq("glitch_valid", 32'(valid[0]), 0);
        send_frame(0, 8'h96, 0, 2'b00, 1);
        flush_compare("glitch");

        // Held word with consumer stalled: second frame dropped with overrun.
        ready[0] = 1'b0;
        send_frame(0, 8'h11, 0, 2'b00, 1);
        cyc(BC);
        send_frame(0, 8'h22, 0, 2'b00, 0);
        cyc(BC);
        check_eq("ovr_valid_held", 32'(valid[0]), 1);
        check_eq("ovr_data_held", 32'(data[0]), 32'h11);
        check_eq("ovr_pulses", 32'(ov_cnt[0]), 1);
        ready[0] = 1'b1;
        cyc(1);
        check_eq("ovr_valid_clr", 32'(valid[0]), 0);
        flush_compare("overrun");

        // Reset in the middle of bit 4 abandons the frame.
        fork
            send_frame(0, 8'hFF, 0, 2'b00, 0);
            begin
                cyc(5 * BC + HALF);
                rst = 1'b1;
                #1;
                check_eq("midrst_valid", 32'(valid[0]), 0);
                cyc(2);
                rst = 1'b0;
            end
        join
        cyc(BC);
        send_frame(0, 8'h5A, 0, 2'b00, 1);
        flush_compare("midrst");

        for (int n = 0; n < 32; n++) begin
            i  = $urandom_range(0, 3);
            d  = 8'($urandom);
            bp = (PAR[i] != 0) && ($urandom_range(0, 3) == 0);
            bs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, (SB[i] == 2) ? 3 : 1)) : 2'b00;
            send_frame(i, d, bp, bs, 1);
            cyc($urandom_range(BC + 4, 3 * BC));
        end
        flush_compare("random");

        check_eq("ovr_total0", 32'(ov_cnt[0]), 1);
        check_eq("ovr_total1", 32'(ov_cnt[1]), 0);
        check_eq("ovr_total2", 32'(ov_cnt[2]), 0);
        check_eq("ovr_total3", 32'(ov_cnt[3]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
